// File: rtl/wb_master_port_if.sv
// Core-side request/response channels and Wishbone classic bus for wb_master_port.
//   master modport: the bus initiator (drives req_ready_o, rsp_*, wbm_* outputs)
//   slave modport : the environment (core-side agent plus Wishbone slave)
// Parameters: WB_AD_WIDTH (address width), WB_DAT_WIDTH (data width, multiple of 8).
interface wb_master_port_if #(
    parameter int unsigned WB_AD_WIDTH  = 32,
    parameter int unsigned WB_DAT_WIDTH = 32
);
    localparam int unsigned SEL_W = WB_DAT_WIDTH / 8;

    // core-side request channel
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_we_i;
    logic [WB_AD_WIDTH-1:0]  req_addr_i;
    logic [WB_DAT_WIDTH-1:0] req_wdata_i;
    logic [SEL_W-1:0]        req_sel_i;

    // core-side response channel
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [WB_DAT_WIDTH-1:0] rsp_rdata_o;
    logic                    rsp_err_o;

    // Wishbone classic bus
    logic                    wbm_cyc_o;
    logic                    wbm_stb_o;
    logic                    wbm_we_o;
    logic [WB_AD_WIDTH-1:0]  wbm_addr_o;
    logic [WB_DAT_WIDTH-1:0] wbm_wdata_o;
    logic [SEL_W-1:0]        wbm_sel_o;
    logic [WB_DAT_WIDTH-1:0] wbm_rdata_i;
    logic                    wbm_ack_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_wdata_o, wbm_sel_o,
        input  wbm_rdata_i, wbm_ack_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_wdata_o, wbm_sel_o,
        output wbm_rdata_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_master_port.sv
// Wishbone classic single-access initiator: one valid/ready request becomes one
// Wishbone read or write cycle; read data (or a timeout error) is returned on a
// valid/ready response channel. Only one access is outstanding at a time.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; clears all outputs at once
//   bus  - wb_master_port_if.master: req_* request, rsp_* response, wbm_* Wishbone
// Parameters: WB_AD_WIDTH, WB_DAT_WIDTH, TIMEOUT_CYCLES (used with the macro below).
// Build option: define WBM_TIMEOUT_EN to end unacknowledged cycles after
// TIMEOUT_CYCLES cycles with rsp_err_o=1; otherwise BUS waits for ACK forever
// and rsp_err_o is tied low.
module wb_master_port #(
    parameter int unsigned WB_AD_WIDTH    = 32,
    parameter int unsigned WB_DAT_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst,
    wb_master_port_if.master bus
);
    localparam int unsigned SEL_W = WB_DAT_WIDTH / 8;

    // Elaboration-time guard on the timeout length
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_master_port: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [WB_AD_WIDTH-1:0]  addr_q, addr_d;
    logic [WB_DAT_WIDTH-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [WB_DAT_WIDTH-1:0] rdata_q, rdata_d;

`ifdef WBM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
`ifdef WBM_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
`ifdef WBM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
`ifdef WBM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                // ready_q is still low for the first cycle after reset release
                if (ready_q && bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    sel_d   = bus.req_sel_i;
                    cyc_d   = 1'b1;
                    ready_d = 1'b0;
`ifdef WBM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = BUS;
                end else begin
                    ready_d = 1'b1;
                end
            end

            BUS: begin
                // ACK takes priority over a timeout on the same edge
                if (bus.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = we_q ? '0 : bus.wbm_rdata_i;
`ifdef WBM_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef WBM_TIMEOUT_EN
                // cnt_q counts completed BUS cycles, so N-1 here means cyc was high N cycles
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready_o = ready_q;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = cyc_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_addr_o  = addr_q;
    assign bus.wbm_wdata_o = wdata_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rdata_q;
`ifdef WBM_TIMEOUT_EN
    assign bus.rsp_err_o   = err_q;
`else
    assign bus.rsp_err_o   = 1'b0;
`endif

endmodule
